// File: rtl/cpu_clk_ctrl_if.sv
// Board-side signals of the CPU clock-enable controller.
// The master drives the raw controls and halt; the slave is the controller.
interface cpu_clk_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             step_btn;
  logic             mode_sw;
  logic             halt;
  logic             cpu_ce;
  logic [WIDTH-1:0] step_cnt;
  logic             run_led;
  logic             halt_led;

  modport master (
    output step_btn, mode_sw, halt,
    input  cpu_ce, step_cnt, run_led, halt_led
  );

  modport slave (
    input  step_btn, mode_sw, halt,
    output cpu_ce, step_cnt, run_led, halt_led
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: debounced single-step or free-running
// enable pulses, with halt handling and an executed-cycle counter.
module cpu_clk_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEB_LEN   = 50000,
  parameter int unsigned DEB_WIDTH = 16,
  parameter int unsigned RUN_DIV   = 25000000,
  parameter int unsigned DIV_WIDTH = 25
) (
  input  logic          clk,
  input  logic          rst,
  cpu_clk_ctrl_if.slave bus
);

  localparam int unsigned NUM_IN = 2;
  localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_LEN - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_STEP   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Bit 0 is the step button, bit 1 the mode switch.
  logic [NUM_IN-1:0]    raw_c;
  logic [NUM_IN-1:0]    sync1;
  logic [NUM_IN-1:0]    sync2;
  logic [NUM_IN-1:0]    stable;
  logic [DEB_WIDTH-1:0] deb_cnt [NUM_IN];
  logic                 step_prev;
  logic                 step_strobe_c;
  logic                 mode_db_c;

  state_t               state;
  state_t               state_nx;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_nx;
  logic                 ce_nx;
  logic                 cpu_ce_q;
  logic [WIDTH-1:0]     step_cnt_q;

  assign raw_c = {bus.mode_sw, bus.step_btn};

  // Two-flop synchronisers followed by counting debouncers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      step_prev <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) deb_cnt[i] <= '0;
    end else begin
      sync1     <= raw_c;
      sync2     <= sync1;
      step_prev <= stable[0];
      for (int i = 0; i < NUM_IN; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_WIDTH'(1);
        end
      end
    end
  end

  assign step_strobe_c = stable[0] & ~step_prev;
  assign mode_db_c     = stable[1];

  // State register plus the datapath registers it drives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STEP;
      div_q      <= '0;
      cpu_ce_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state      <= state_nx;
      div_q      <= div_nx;
      cpu_ce_q   <= ce_nx;
      step_cnt_q <= step_cnt_q + WIDTH'(cpu_ce_q);
    end
  end

  // Next state; in RUN a halt outranks a mode change.
  always_comb begin
    state_nx = state;
    case (state)
      ST_STEP:   if (mode_db_c) state_nx = ST_RUN;
      ST_RUN: begin
        if (bus.halt)       state_nx = ST_HALTED;
        else if (!mode_db_c) state_nx = ST_STEP;
      end
      ST_HALTED: if (!mode_db_c) state_nx = ST_STEP;
      default:   state_nx = ST_STEP;
    endcase
  end

  // Pulse and divider control; leaving RUN suppresses the terminal pulse.
  always_comb begin
    ce_nx  = 1'b0;
    div_nx = '0;
    case (state)
      ST_STEP: ce_nx = step_strobe_c;
      ST_RUN: begin
        if (state_nx == ST_RUN) begin
          if (div_q == DIV_LAST) begin
            ce_nx = 1'b1;
          end else begin
            div_nx = div_q + DIV_WIDTH'(1);
          end
        end
      end
      default: ce_nx = 1'b0;
    endcase
  end

  assign bus.cpu_ce   = cpu_ce_q;
  assign bus.step_cnt = step_cnt_q;
  assign bus.run_led  = (state == ST_RUN);
  assign bus.halt_led = (state == ST_HALTED);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with short debounce and divider lengths.
module tb_cpu_clk_ctrl;

  localparam int unsigned NVEC = 50;

  typedef struct {
    logic       btn;
    logic       mode;
    logic       halt;
    logic       ce;
    logic       run;
    logic       hl;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [NVEC];

  cpu_clk_ctrl_if #(.WIDTH(8)) bus ();

  cpu_clk_ctrl #(
    .WIDTH(8), .DEB_LEN(4), .DEB_WIDTH(3), .RUN_DIV(5), .DIV_WIDTH(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset off-edge, checks outputs clear at once, then releases at a negedge.
  task automatic do_reset(input string name, input logic btn_nx, input logic mode_nx);
    rst = 1'b1;
    #1;
    check({name, "_ce"},   32'(bus.cpu_ce),   0);
    check({name, "_cnt"},  32'(bus.step_cnt), 0);
    check({name, "_run"},  32'(bus.run_led),  0);
    check({name, "_halt"}, 32'(bus.halt_led), 0);
    bus.step_btn = btn_nx;
    bus.mode_sw  = mode_nx;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // k = 0 is the first edge after release; ce_k/run_k give expected cycles.
  task automatic after_release(input string name, input int ce_k, input int run_k);
    for (int k = 0; k < 14; k++) begin
      cycle();
      check($sformatf("%s_ce_k%0d", name, k),  32'(bus.cpu_ce),  32'(k == ce_k));
      check($sformatf("%s_run_k%0d", name, k), 32'(bus.run_led), 32'(k >= run_k));
    end
  endtask

  // Waits for n pulses, checking the free-run period between them.
  task automatic count_pulses(input string name, input int n, input int budget);
    int got  = 0;
    int last = -1;
    int cyc  = 0;
    while (got < n && cyc < budget) begin
      cycle();
      cyc++;
      if (bus.cpu_ce === 1'b1) begin
        if (last >= 0 && (cyc - last) != 5) check({name, "_period"}, 32'(cyc - last), 5);
        last = cyc;
        got++;
      end
    end
    check({name, "_pulses"}, 32'(got), 32'(n));
  endtask

  initial begin
    int pulses;
    int seen;
    bus.step_btn = 1'b0;
    bus.mode_sw  = 1'b0;
    bus.halt     = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      vecs[i].btn  = (i < 10) || (i >= 23 && i < 31);
      vecs[i].mode = (i >= 16 && i < 39);
      vecs[i].halt = (i == 37);
      vecs[i].ce   = (i == 6) || (i == 27) || (i == 32);
      vecs[i].run  = (i >= 22 && i < 37);
      vecs[i].hl   = (i >= 37 && i < 45);
      vecs[i].cnt  = (i < 7) ? 8'd0 : (i < 28) ? 8'd1 : (i < 33) ? 8'd2 : 8'd3;
    end

    repeat (3) @(negedge clk);
    check("rst_ce",   32'(bus.cpu_ce),   0);
    check("rst_cnt",  32'(bus.step_cnt), 0);
    check("rst_run",  32'(bus.run_led),  0);
    check("rst_halt", 32'(bus.halt_led), 0);
    rst = 1'b0;

    // Step press, free-run with a press ignored, halt on terminal count, return to STEP.
    for (int i = 0; i < NVEC; i++) begin
      bus.step_btn = vecs[i].btn;
      bus.mode_sw  = vecs[i].mode;
      bus.halt     = vecs[i].halt;
      cycle();
      check($sformatf("vec%0d_ce", i),   32'(bus.cpu_ce),   32'(vecs[i].ce));
      check($sformatf("vec%0d_run", i),  32'(bus.run_led),  32'(vecs[i].run));
      check($sformatf("vec%0d_halt", i), 32'(bus.halt_led), 32'(vecs[i].hl));
      check($sformatf("vec%0d_cnt", i),  32'(bus.step_cnt), 32'(vecs[i].cnt));
    end

    // Bouncy press: only the settled level produces a single pulse.
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      bus.step_btn = ((c / 2) % 2) == 0;
      cycle();
      if (bus.cpu_ce === 1'b1) pulses++;
    end
    check("bounce_glitch_pulses", 32'(pulses), 0);
    bus.step_btn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (bus.cpu_ce === 1'b1) pulses++;
    end
    check("bounce_hold_pulses", 32'(pulses), 1);
    bus.step_btn = 1'b0;
    for (int c = 0; c < 15; c++) begin
      cycle();
      if (bus.cpu_ce === 1'b1) pulses++;
    end
    check("bounce_release_pulses", 32'(pulses), 1);
    check("bounce_cnt", 32'(bus.step_cnt), 4);

    // Free-run from reset through counter wrap.
    do_reset("wrap_rst", 1'b0, 1'b1);
    after_release("run_start", 11, 6);
    check("run_cnt1", 32'(bus.step_cnt), 1);
    bus.step_btn = 1'b1;
    count_pulses("run_to10", 9, 60);
    cycle();
    check("run_cnt10", 32'(bus.step_cnt), 10);
    bus.step_btn = 1'b0;
    count_pulses("run_to256", 246, 1400);
    check("run_cnt255", 32'(bus.step_cnt), 255);
    cycle();
    check("wrap_cnt0", 32'(bus.step_cnt), 0);
    count_pulses("run_257", 1, 10);
    cycle();
    check("wrap_cnt1", 32'(bus.step_cnt), 1);

    // Reset while a pulse is high, inputs at 1; then a held step button after release.
    count_pulses("run_258", 1, 10);
    bus.step_btn = 1'b1;
    do_reset("pulse_rst", 1'b1, 1'b0);
    after_release("step_after_rst", 6, 99);

    // Reset between free-run pulses, mode switch held through reset.
    bus.step_btn = 1'b0;
    bus.mode_sw  = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      cycle();
      if (bus.run_led === 1'b1) seen = 1;
    end
    check("rerun_enter", 32'(seen), 1);
    count_pulses("rerun", 2, 20);
    cycle();
    check("midrun_ce_low", 32'(bus.cpu_ce), 0);
    do_reset("midrun_rst", 1'b0, 1'b1);
    after_release("midrun_release", 11, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Clock-enable controller that sits directly upstream of the single-cycle CPU top level on the demo board. It turns a raw push-button and a run/step slide switch into a clean one-cycle CPU enable pulse. The pulse is either one per debounced button press (single-step) or a periodic tick (free-run). It also stops free-run when the CPU signals halt, and counts executed cycles for display on the LED/7-segment visualisation stage.

## Interface

Parameters:
- WIDTH, 8, width of the executed-cycle counter (matches CPU data width)
- DEB_LEN, 50000, consecutive stable clk cycles required to accept a new button/switch level
- DEB_WIDTH, 16, debounce counter width; must satisfy 2^DEB_WIDTH > DEB_LEN
- RUN_DIV, 25000000, clk cycles between enable pulses in free-run
- DIV_WIDTH, 25, divider width; must satisfy 2^DIV_WIDTH > RUN_DIV

Ports:
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- step_btn  in  1  raw step push-button, active-high, asynchronous, bouncy
- mode_sw  in  1  raw slide switch, 0 = step mode, 1 = run mode, asynchronous, bouncy
- halt  in  1  synchronous halt request from CPU, active-high, level
- cpu_ce  out  1  registered CPU clock enable, one-cycle pulse
- step_cnt  out  WIDTH  number of cpu_ce pulses issued, wraps
- run_led  out  1  high while in RUN
- halt_led  out  1  high while in HALTED

## Operation

- Synchronisers: step_btn and mode_sw each pass through a 2-flop synchroniser (s1, s2).
- Debouncers, one per input:
  - Each holds a stable value and a counter.
  - If s2 == stable, the counter clears to 0.
  - Otherwise the counter increments. When it is DEB_LEN-1 and s2 still differs, stable <= s2 and the counter clears.
- Step edge: a one-cycle internal strobe on the stable step value going 0→1. The 1→0 transition produces nothing.
- State machine (states STEP, RUN, HALTED; reset state STEP):
  - STEP:
    - Step strobe → cpu_ce pulse.
    - Debounced mode = 1 → RUN, divider cleared to 0.
    - halt is ignored.
  - RUN:
    - The divider counts 0..RUN_DIV-1 and wraps.
    - At terminal count RUN_DIV-1 → cpu_ce pulse.
    - Debounced mode = 0 → STEP.
    - halt = 1 → HALTED.
    - Step strobes are ignored.
  - HALTED:
    - No pulses; step strobes are ignored.
    - Debounced mode = 0 → STEP.
    - Deasserting halt does not leave HALTED.
- Priority in RUN when events coincide: halt > mode = 0 > terminal-count pulse. The state exits with no pulse in that cycle, and the divider is cleared.
- step_cnt increments by 1 on every cycle in which cpu_ce is high. It wraps from 2^WIDTH-1 to 0.
- run_led and halt_led are decoded from the state register, not from inputs.

## Timing

- Reset (asynchronous, immediate):
  - Outputs: cpu_ce = 0, step_cnt = 0, run_led = 0, halt_led = 0.
  - Internal: state = STEP, synchronisers = 0, stable values = 0, debounce counters = 0, divider = 0.
- Step latency:
  - Let e0 be the first clk edge sampling step_btn high, with the input steady from then on.
  - Stable step goes high at edge e0+DEB_LEN+1.
  - cpu_ce is high for exactly one cycle, following edge e0+DEB_LEN+2.
- Mode latency: debounced mode changes at e0+DEB_LEN+1, and the state changes at the next edge.
- Free-run period:
  - The first cpu_ce occurs RUN_DIV cycles after the edge entering RUN.
  - Thereafter cpu_ce pulses every RUN_DIV cycles exactly, with high time 1 cycle.
- Bounce: any input glitch shorter than DEB_LEN cycles leaves the stable value unchanged and restarts the count.
- Halt: sampled every cycle in RUN. The state shows HALTED on the edge after halt is seen, and no later cpu_ce is issued.
- Reset mid-pulse or mid-debounce aborts immediately; no pulse is issued after reset release until the inputs are re-debounced.

## Test plan

All scenarios use WIDTH=8, DEB_LEN=4, DEB_WIDTH=3, RUN_DIV=5, DIV_WIDTH=3.

- Reset: assert rst mid-simulation with inputs at 1 → all outputs 0 at once. After release with step_btn held, exactly one cpu_ce at e0+6.
- Bouncy press: step_btn toggles every 2 cycles for 20 cycles, then holds 1 for 10 cycles, then 0 → exactly one cpu_ce, step_cnt = 1, no pulse on release.
- Free-run: mode_sw = 1 held → run_led = 1; cpu_ce every 5 cycles; after 10 pulses step_cnt = 10; step_btn presses ignored.
- Halt collision: assert halt on the divider's terminal-count cycle → no cpu_ce, halt_led = 1 next cycle. Drop halt → stays HALTED. mode_sw = 0 → STEP, halt_led = 0.
- Wrap: 256 free-run pulses from reset → step_cnt = 0. The 257th pulse → step_cnt = 1.
- Reset mid-run: assert rst between pulses → cpu_ce = 0, run_led = 0, step_cnt = 0. After release with mode_sw still 1, RUN re-entered after debounce, and the first pulse arrives 5 cycles later.
